// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, FSM state encoding and S-box helpers.
// Used by the key-preparation block and the decrypt core.
package present_pkg;

    localparam int KEY_W     = 80;
    localparam int BLK_W     = 64;
    localparam int ROUNDS_80 = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_key_round.sv
// One forward PRESENT-80 key-schedule update; purely combinational, no flow control.
module present_key_round
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [4:0]       round,
    output logic [KEY_W-1:0] next_key
);

    logic [KEY_W-1:0] rot;

    always_comb begin
        rot               = {key[18:0], key[79:19]};
        next_key          = rot;
        next_key[79:76]   = sbox(rot[79:76]);
        next_key[19:15]   = rot[19:15] ^ round;
    end

endmodule

// File: rtl/present_key_prep.sv
// Runs the forward key schedule ROUNDS times, one update per clock, to hand the K32 state to decrypt.
// ready rises ROUNDS cycles after an accepted start; start is ignored while busy.
module present_key_prep #(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] master_key,
    output logic [KEY_W-1:0] last_key,
    output logic             ready,
    output logic             busy,
    output logic [4:0]       round
);

    import present_pkg::*;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    state_t           state, state_nxt;
    logic [KEY_W-1:0] key_reg, key_nxt, key_upd;
    logic [4:0]       round_nxt;

    present_key_round u_key_round (
        .key      (key_reg),
        .round    (round),
        .next_key (key_upd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            key_reg <= '0;
            round   <= '0;
        end else begin
            state   <= state_nxt;
            key_reg <= key_nxt;
            round   <= round_nxt;
        end
    end

    // DONE accepts start exactly like IDLE, so a restart drops ready on the same edge.
    always_comb begin
        state_nxt = state;
        key_nxt   = key_reg;
        round_nxt = round;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    key_nxt   = master_key;
                    round_nxt = 5'd1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                key_nxt = key_upd;
                if (round == LAST_ROUND) begin
                    state_nxt = DONE;
                end else begin
                    round_nxt = round + 5'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last_key = key_reg;
    assign ready    = (state == DONE);
    assign busy     = (state == RUN);

endmodule

// File: tb/tb_present_key_prep.sv
// Randomized bench for present_key_prep with an arithmetic PRESENT-80 model
// (key schedule, encrypt and decrypt) used to check the delivered K32 state.
module tb_present_key_prep;

    localparam logic [79:0] K32_STATE_0 = 80'h6dab31744f41d7008759;
    localparam logic [79:0] ONE_ROUND_0 = 80'hc0000000000000008000;
    localparam logic [3:0]  SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic        clk = 1'b0;
    logic        reset, start;
    logic [79:0] master_key;
    logic [79:0] last_key, last_key1;
    logic        ready, busy, ready1, busy1;
    logic [4:0]  round, round1;
    logic        mon_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    present_key_prep #(.KEY_W(80), .ROUNDS(31)) dut (
        .clk(clk), .reset(reset), .start(start), .master_key(master_key),
        .last_key(last_key), .ready(ready), .busy(busy), .round(round)
    );

    present_key_prep #(.KEY_W(80), .ROUNDS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .master_key(master_key),
        .last_key(last_key1), .ready(ready1), .busy(busy1), .round(round1)
    );

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("busy_ready_excl", 80'(busy & ready), 80'(0));
            check_eq("busy_ready_excl_r1", 80'(busy1 & ready1), 80'(0));
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] sbi(input logic [3:0] y);
        logic [3:0] x = 4'h0;
        for (int i = 0; i < 16; i++) if (SB[i] == y) x = 4'(i);
        return x;
    endfunction

    function automatic logic [79:0] upd(input logic [79:0] k, input int r);
        logic [79:0] t;
        t = (k << 61) | (k >> 19);
        t[79:76] = SB[t[79:76]];
        t[19:15] = t[19:15] ^ 5'(r);
        return t;
    endfunction

    function automatic logic [79:0] inv_upd(input logic [79:0] k, input int r);
        logic [79:0] t;
        t = k;
        t[19:15] = t[19:15] ^ 5'(r);
        t[79:76] = sbi(t[79:76]);
        return (t << 19) | (t >> 61);
    endfunction

    function automatic logic [79:0] ks(input logic [79:0] mk, input int n);
        logic [79:0] k = mk;
        for (int r = 1; r <= n; r++) k = upd(k, r);
        return k;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        for (int n = 0; n < 16; n++) o[n*4 +: 4] = inv ? sbi(s[n*4 +: 4]) : SB[s[n*4 +: 4]];
        return o;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        o[63] = s[63];
        for (int i = 0; i < 63; i++) begin
            if (inv) o[i] = s[(i * 16) % 63];
            else     o[(i * 16) % 63] = s[i];
        end
        return o;
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [79:0] mk);
        logic [63:0] s = pt;
        logic [79:0] k = mk;
        for (int i = 1; i <= 31; i++) begin
            s = s ^ k[79:16];
            s = p_layer(sbox_layer(s, 1'b0), 1'b0);
            k = upd(k, i);
        end
        return s ^ k[79:16];
    endfunction

    function automatic logic [63:0] decrypt(input logic [63:0] ct, input logic [79:0] lk);
        logic [79:0] k = lk;
        logic [63:0] s;
        s = ct ^ k[79:16];
        for (int i = 31; i >= 1; i--) begin
            k = inv_upd(k, i);
            s = sbox_layer(p_layer(s, 1'b1), 1'b1) ^ k[79:16];
        end
        return s;
    endfunction

    function automatic logic [79:0] rand80();
        return {$urandom_range(65535, 0), $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(inout int lat);
        while (!ready && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_key(input logic [79:0] k, output int lat);
        master_key = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        wait_ready(lat);
    endtask

    initial begin
        int          lat;
        logic [79:0] first, k;
        logic [63:0] pt;

        reset = 1'b1; start = 1'b0; master_key = '0;
        tick(); tick();
        reset = 1'b0;
        mon_en = 1'b1;
        check_eq("rst_ready", 80'(ready), 80'(0));
        check_eq("rst_busy", 80'(busy), 80'(0));
        check_eq("rst_round", 80'(round), 80'(0));
        check_eq("rst_last_key", last_key, 80'(0));

        // Key 0, full schedule, with the ROUNDS=1 instance watched after one update.
        master_key = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("load_busy", 80'(busy), 80'(1));
        check_eq("load_round", 80'(round), 80'(1));
        tick();
        check_eq("r1_last_key", last_key1, ONE_ROUND_0);
        check_eq("r1_model", last_key1, ks(80'(0), 1));
        check_eq("r1_ready", 80'(ready1), 80'(1));
        lat = 1;
        wait_ready(lat);
        check_eq("k0_latency", 80'(lat), 80'(31));
        check_eq("k0_last_key", last_key, K32_STATE_0);
        check_eq("k0_model", last_key, ks(80'(0), 31));
        check_eq("k0_round_hold", 80'(round), 80'(31));
        check_eq("k0_decrypt", 80'(decrypt(64'h5579c1387b228445, last_key)), 80'(0));
        first = last_key;

        // DONE holds its outputs while start stays low.
        master_key = rand80();
        repeat ($urandom_range(6, 2)) tick();
        check_eq("done_hold_key", last_key, first);
        check_eq("done_hold_ready", 80'(ready), 80'(1));

        // Restart from DONE with the same key.
        master_key = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart_ready_drop", 80'(ready), 80'(0));
        check_eq("restart_busy", 80'(busy), 80'(1));
        check_eq("restart_round", 80'(round), 80'(1));
        lat = 0;
        wait_ready(lat);
        check_eq("restart_latency", 80'(lat), 80'(31));
        check_eq("restart_key", last_key, first);

        // Reset 10 cycles into a run aborts it cleanly.
        master_key = rand80();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_ready", 80'(ready), 80'(0));
        check_eq("abort_busy", 80'(busy), 80'(0));
        check_eq("abort_round", 80'(round), 80'(0));
        check_eq("abort_last_key", last_key, 80'(0));
        run_key(80'(0), lat);
        check_eq("post_abort_latency", 80'(lat), 80'(31));
        check_eq("post_abort_key", last_key, K32_STATE_0);

        // Key change and start pulse in cycle 5 of a run are both ignored.
        master_key = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        master_key = {80{1'b1}};
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 5;
        wait_ready(lat);
        check_eq("ignore_latency", 80'(lat), 80'(31));
        check_eq("ignore_key", last_key, K32_STATE_0);

        // Random keys: compare the schedule and round-trip a random block.
        for (int n = 0; n < 6; n++) begin
            k = rand80();
            pt = {$urandom, $urandom};
            run_key(k, lat);
            check_eq("rand_latency", 80'(lat), 80'(31));
            check_eq("rand_key", last_key, ks(k, 31));
            check_eq("rand_round", 80'(round), 80'(31));
            check_eq("rand_roundtrip", 80'(decrypt(encrypt(pt, k), last_key)), 80'(pt));
        end

        // start held high: accepted, ignored during RUN, re-accepted on the first DONE cycle.
        k = rand80();
        master_key = k;
        start = 1'b1;
        tick();
        repeat (31) tick();
        check_eq("held_ready", 80'(ready), 80'(1));
        check_eq("held_key", last_key, ks(k, 31));
        tick();
        check_eq("held_reaccept_ready", 80'(ready), 80'(0));
        check_eq("held_reaccept_round", 80'(round), 80'(1));
        check_eq("held_reaccept_key", last_key, k);
        start = 1'b0;
        lat = 0;
        wait_ready(lat);
        check_eq("held_final_key", last_key, ks(k, 31));

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/present_key_prep.md
Name: present_key_prep

Overview:
- Upstream neighbour of the PRESENT-80 decryption core (`decrypt`).
- Takes the 80-bit master key and runs the forward PRESENT-80 key schedule for ROUNDS updates, one update per clock.
- Delivers the final key-register state, whose [79:16] is round key K32, to the `key` input of `decrypt`; the core then runs the inverse schedule from it.
- Raises `ready` to tell the controller that `decrypt` may be reset and loaded.

Parameters:
- KEY_W, 80, key register width; fixed for PRESENT-80.
- ROUNDS, 31, number of forward schedule updates. 31 gives the K32 state; smaller values are for debug and test only.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- master_key  input  80  user key; sampled on the accepted start edge only.
- last_key  output  80  final key register state; valid while ready=1.
- ready  output  1  level, high in DONE.
- busy  output  1  high in RUN.
- round  output  5  current round counter (debug and bench visibility).

Behaviour:
- Reset (synchronous, highest priority, including mid-RUN):
  - state=IDLE; key_reg=0; round=0; ready=0; busy=0; last_key=0.
  - Reset asserted in RUN aborts the computation; no partial result is exposed.
- States and transitions:
  - IDLE: start=1 at edge E0 → key_reg<=master_key, round<=1, state<=RUN.
  - RUN: each edge applies one update using the current round value.
    - round<ROUNDS → round<=round+1.
    - round==ROUNDS → state<=DONE, ready<=1.
    - start is ignored throughout RUN.
  - DONE: ready=1 and last_key=key_reg, both held stable indefinitely.
    - start=1 → behaves exactly as the IDLE transition: reload master_key, round<=1, RUN; ready falls on that same edge.
- Update function, with K = key_reg and all bit indices in the current state:
  - Step 1, rotate: K <= {K[18:0], K[79:19]} (left rotate by 61).
  - Step 2, S-box: K[79:76] <= S(K[79:76]).
  - Step 3, counter: K[19:15] <= K[19:15] ^ round[4:0].
  - S-box table: 0→C, 1→5, 2→6, 3→B, 4→9, 5→0, 6→A, 7→D, 8→3, 9→E, A→F, B→8, C→4, D→7, E→1, F→2.
- Latency: updates occur on edges E1..E_ROUNDS; ready=1 is visible after edge E_ROUNDS, i.e. ROUNDS cycles after the start edge.
- busy and ready are never both high. round holds ROUNDS while in DONE.
- last_key is driven from key_reg continuously. Its value is guaranteed only while ready=1.
- start held high continuously: accepted once in IDLE, ignored in RUN, then re-accepted on the first DONE cycle. This restarts the run; it is legal but wastes the result.
- master_key changing during RUN has no effect.

Decomposition:
- Shared package present_pkg holds:
  - KEY_W=80, BLK_W=64, ROUNDS_80=31.
  - S-box and inverse S-box constant functions, shared with the decrypt core.
  - State encoding typedef {IDLE, RUN, DONE}.
- One natural sub-module: present_key_round. It is combinational: 80-bit key in, 5-bit round in, 80-bit updated key out. The FSM instantiates it once.

Test Plan:
- Reset, then start with master_key=0 (ROUNDS=31):
  - ready rises exactly 31 cycles after the start edge.
  - last_key=80'h6dab31744f41d7008759, so last_key[79:16]=64'h6dab31744f41d700 (K32).
- Parameter ROUNDS=1, master_key=0:
  - after one edge last_key=80'hc0000000000000008000 and ready=1.
- Reset asserted 10 cycles into RUN:
  - next cycle shows state IDLE, ready=0, busy=0, last_key=0, round=0.
  - a fresh start with key 0 again yields 80'h6dab31744f41d7008759 after 31 cycles.
- Change master_key to 80'hffffffffffffffffffff at cycle 5 of a key-0 RUN, with start pulsed at the same time:
  - both are ignored; result is 80'h6dab31744f41d7008759 at cycle 31.
- Restart from DONE:
  - ready drops on the start edge.
  - result recomputes and matches the first run for the same key.
  - busy and ready are never simultaneously high (assertion).
- End-to-end: key 0 produces last_key, which feeds `decrypt` with ciphertext 64'h5579c1387b228445 → plaintext 64'h0000000000000000.
